// File: rtl/seq_word_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shift register,
// streaming back-to-back words onto x with no idle cycle between them.
module seq_word_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   buf_word, buf_word_nxt;
  logic           buf_full, buf_full_nxt;
  logic [W-1:0]   sh, sh_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           accept;
  logic           load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_word <= '0;
      buf_full <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      buf_word <= buf_word_nxt;
      buf_full <= buf_full_nxt;
      sh       <= sh_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    buf_word_nxt = buf_word;
    buf_full_nxt = buf_full;
    sh_nxt       = sh;
    cnt_nxt      = cnt;
    accept       = din_valid && !buf_full;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (buf_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sh_nxt  = MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
          cnt_nxt = cnt + CW'(1);
        end else if (buf_full) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
          sh_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Load needs a full buffer and accept needs an empty one, so they never collide.
    if (load) begin
      sh_nxt       = buf_word;
      cnt_nxt      = '0;
      buf_full_nxt = 1'b0;
    end
    if (accept) begin
      buf_word_nxt = din;
      buf_full_nxt = 1'b1;
    end
  end

  assign din_ready = !buf_full;
  assign x_valid   = (state == SHIFT);
  assign x         = x_valid && (MSB_FIRST ? sh[W-1] : sh[0]);
  assign word_done = (state == SHIFT) && (cnt == LAST);
  assign busy      = (state == SHIFT) || buf_full;

endmodule

// File: doc/seq_word_serializer.md
# seq_word_serializer

Parallel-to-serial front end for the team's serial sequence detectors. It accepts W-bit words over a valid/ready handshake, buffers one word, and emits them one bit per clock on a serial line `x` with a qualifying `x_valid`. Words arriving back-to-back are streamed with no idle cycle between them. Downstream detectors sample `x` every clock, so idle cycles drive `x`=0.

## Interface

Parameters:
- `W`, default 8: word width. Legal range is W ≥ 2.
- `MSB_FIRST`, default 1:
  - 1: bit W-1 is sent first.
  - 0: bit 0 is sent first.

Ports:
- `clk`  in  1  The single clock. All state changes on its rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `din`  in  W  Parallel word to serialize.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  Block can accept a word this cycle. Equal to `!buf_full`.
- `x`  out  1  Serial data bit. Held at 0 when `x_valid`=0.
- `x_valid`  out  1  `x` carries a payload bit this cycle.
- `word_done`  out  1  High during the cycle the last bit of a word is on `x`.
- `busy`  out  1  Equal to `(state==SHIFT) || buf_full`.

## Operation

Internal state:
- `buf` (W bits) and `buf_full`: one-word holding register.
- `sh` (W bits): shift register.
- `cnt` (clog2(W) bits): bit index of the word currently being sent.
- `state`, one of IDLE or SHIFT.

Accept rule:
- A word is accepted on a rising edge where `din_valid && din_ready`.
- On accept, `buf`<=`din` and `buf_full`<=1.
- While `din_valid`=1 and `din_ready`=0, the word is not taken. Upstream holds `din` stable.

Output decode (combinational from registers only):
- `x_valid` = (state==SHIFT).
- When `x_valid`=1:
  - `x` = `sh[W-1]` if MSB_FIRST=1.
  - `x` = `sh[0]` if MSB_FIRST=0.
- When `x_valid`=0, `x`=0.
- `word_done` = (state==SHIFT && cnt==W-1).

State transitions:
- IDLE, `buf_full`=1: on the edge, `sh`<=`buf`, `cnt`<=0, `buf_full`<=0, go to SHIFT.
- IDLE, `buf_full`=0: stay in IDLE.
- SHIFT, cnt<W-1: shift `sh` by one toward the output end (fill with 0), `cnt`<=`cnt`+1.
- SHIFT, cnt==W-1, `buf_full`=1: `sh`<=`buf`, `cnt`<=0, `buf_full`<=0, stay in SHIFT. No gap between words.
- SHIFT, cnt==W-1, `buf_full`=0: go to IDLE, `sh`<=0.

Simultaneous accept and load on one edge:
- Accept requires `buf_full`=0, so accept and load (which requires `buf_full`=1) never coincide.
- At most one word is ever buffered, plus the one in `sh`.

Reset values (while `rst_n`=0):
- `state`=IDLE; `buf_full`=0; `sh`=0; `buf`=0; `cnt`=0.
- Outputs: `x`=0, `x_valid`=0, `word_done`=0, `busy`=0, `din_ready`=1.
- Handshakes during reset are ignored: no word is captured.

Reset mid-operation:
- The word in flight and the buffered word are discarded.
- `x_valid` drops asynchronously.
- Nothing resumes after release.

## Timing

Latency:
- Word accepted at edge T → `buf_full`=1 after T.
- Load into `sh` at edge T+1.
- First bit on `x` with `x_valid`=1 in the cycle after T+1.
- Last bit appears W-1 cycles after the first, with `word_done`=1.

Throughput:
- Sustained throughput is one word per W cycles with `x_valid` continuously high.
- `din_ready` is 0 from the accept edge until the load edge that empties `buf`.
- In sustained streaming, `din_ready` goes high for one or more cycles per word, so a waiting upstream is accepted within W-1 cycles.

All outputs change only on `clk` edges, except under asynchronous reset.

## Test plan

All scenarios use W=8, MSB_FIRST=1 unless stated.

1. **Reset values:** hold `rst_n`=0 with `din_valid`=1, `din`=8'hFF → `x`=0, `x_valid`=0, `busy`=0, `word_done`=0, `din_ready`=1. After release, no bits are emitted.
2. **Single word:** 8'hB5 accepted at edge T → `x_valid` rises after edge T+1. `x` = 1,0,1,1,0,1,0,1 on consecutive cycles. `word_done`=1 only on the 8th bit. Then `x_valid`=0, `x`=0, `busy`=0.
3. **Back-to-back words:** 8'hB0 then 8'h0B, with `din_valid` held high → 16 contiguous `x_valid` cycles carrying 1,0,1,1,0,0,0,0,0,0,0,0,1,0,1,1. `word_done` high twice, 8 cycles apart. `din_ready` low while `buf_full`. Neither word is lost or duplicated.
4. **LSB-first order:** MSB_FIRST=0, 8'h0D → `x` = 1,0,1,1,0,0,0,0.
5. **Reset mid-word:** send 8'hB5 with 8'h0F buffered, assert `rst_n`=0 after 3 bits → `x_valid`=0 immediately and both words are discarded. After release, 8'hFF yields exactly 8 cycles of `x`=1.
6. **Backpressure:** 3 words offered while the first is shifting → `din` is held until `din_ready`=1. Output stream equals the 3 words in order with no gaps.
